i2c_slave_responder: RTL and testbench
======================================

# i2c_slave_responder

Synthesizable I2C target (responder) that answers the I2CMB master at a fixed 7-bit slave address, forming the far end of the I2C bus the I2CMB core drives. Detects START/STOP, matches the address, ACKs, deserializes write bytes to a local byte stream and serializes read bytes fetched from a local request/data port. Oversamples SCL/SDA on the system clock; drives SDA open-drain only; never drives SCL.

## Interface
- SLAVE_ADDR, 7'h11, address this target ACKs
- FILTER_LEN, 3, consecutive equal samples required to accept a new SCL/SDA level (used only with filter macro)
- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- scl_i  in  1  bus SCL level
- sda_i  in  1  bus SDA level
- sda_oe_o  out  1  1 = pull SDA low; 0 = release
- rx_data_o  out  8  last write byte received, MSB first on bus
- rx_valid_o  out  1  one-cycle pulse, rx_data_o valid
- rx_ready_i  in  1  local sink can accept a byte; low at byte end forces NACK
- tx_req_o  out  1  one-cycle pulse requesting next read byte
- tx_data_i  in  8  read byte, sampled in the tx_req_o cycle
- dir_o  out  1  R/W bit of current transfer (0 WRITE, 1 READ)
- busy_o  out  1  high from START to STOP

## Operation
- Input path: 2-flop synchronizer per line, then edge detector on registered values. SCL rise/fall, START (SDA fall, SCL high), STOP (SDA rise, SCL high) are one-cycle internal events.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- IDLE: START -> ADDR, bit counter = 0, busy_o = 1.
- ADDR: shift SDA on each SCL rise, MSB first; after 8th rise compare [7:1] with SLAVE_ADDR, latch dir_o = bit 0. Match -> ADDR_ACK; mismatch -> WAIT_STOP, SDA never driven.
- ADDR_ACK: on next SCL fall assert sda_oe_o; on following fall release, then go WR_BYTE (dir 0) or RD_BYTE (dir 1). For RD, tx_req_o pulses in that same fall cycle, tx_data_i loaded into shift register, sda_oe_o = ~bit7.
- WR_BYTE: 8 rises shift data; at 8th rise rx_data_o updated; if rx_ready_i = 1, rx_valid_o pulses next cycle and WR_ACK ACKs; else no pulse, byte dropped, WR_ACK NACKs (sda_oe_o stays 0) and -> WAIT_STOP after the 9th clock.
- RD_BYTE: on each SCL fall present next bit (sda_oe_o = ~bit); after 8th bit's fall release SDA -> RD_ACK.
- RD_ACK: sample SDA on 9th rise. 0 (ACK): at next fall pulse tx_req_o, load byte, -> RD_BYTE. 1 (NACK): -> WAIT_STOP, SDA released.
- WAIT_STOP: SDA released; waits for START or STOP.
- START in any non-IDLE state (repeated START): -> ADDR, counter cleared, SDA released same cycle. STOP in any state: -> IDLE, sda_oe_o = 0, busy_o = 0, partial byte discarded (no rx_valid_o).
- START and STOP cannot coincide (require opposite SDA edges); START has priority over SCL edge in same cycle.

## Timing
- Reset values: sda_oe_o 0, rx_data_o 8'h00, rx_valid_o 0, tx_req_o 0, dir_o 0, busy_o 0, state IDLE. Reset mid-transfer releases SDA on the first clk_i edge with rst_i high.
- Pin-to-event latency: 3 clk_i (2 sync + edge register); +FILTER_LEN with filter.
- sda_oe_o changes exactly 1 clk_i after the detected SCL-fall event.
- rx_valid_o: 1 clk_i after the 8th SCL-rise event.
- Requirement: SCL high and low phases each ≥ 8 clk_i (≥ 8+FILTER_LEN with filter); SDA hold after SCL fall on bus ≥ 4 clk_i.

## Configuration
- I2C_SLAVE_GLITCH_FILTER_EN defined: after synchronizer, each line passes a saturating counter filter; filtered level changes only after FILTER_LEN consecutive identical samples; pulses shorter than FILTER_LEN clk_i ignored.
- Undefined: synchronizer output feeds edge detector directly; FILTER_LEN unused; any 1-cycle glitch is a valid edge.

## Test plan
- Write 0x22 then 0xA5 to address 0x11, rx_ready_i = 1 -> ACK on address and both bytes; rx_valid_o pulses twice with 0x22, 0xA5; dir_o = 0.
- Read from 0x11, tx_data_i = 0x3C then 0xF0, master ACK then NACK -> bus bits 0x3C, 0xF0; tx_req_o pulses exactly twice; SDA released after NACK; busy_o low after STOP.
- Address 0x12 -> no ACK (SDA high on 9th clock), no rx/tx pulses, sda_oe_o 0 throughout.
- Write with rx_ready_i = 0 at byte end -> NACK, no rx_valid_o; repeated START + write 0x55 to 0x11 -> ACK, rx_data_o 0x55.
- STOP after 4 data bits, then rst_i pulsed while sda_oe_o = 1 during ACK -> no rx_valid_o; sda_oe_o 0 next cycle; all outputs at reset values.
- Filter build: 1-cycle SDA low glitch while SCL high -> no START, state IDLE; non-filter build same stimulus -> busy_o = 1.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C target at a fixed 7-bit address: START/STOP detect, address match, write deserialize, read serialize.
// Optional glitch filter on SCL/SDA enabled by defining I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h11
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  , parameter int unsigned FILTER_LEN = 3
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       tx_req_o,
  input  logic [7:0] tx_data_i,
  output logic       dir_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_filt, sda_filt;
  logic       scl_q, scl_d, sda_q, sda_d;
  logic       scl_rise, scl_fall, start, stop;

  state_t     state;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic       phase;
  logic       nack;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  // A new level is accepted only after FILTER_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_filt <= 1'b1;
      sda_filt <= 1'b1;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
    end else begin
      if (scl_sync[1] == scl_filt) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_filt <= scl_sync[1];
        scl_cnt  <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_filt) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_filt <= sda_sync[1];
        sda_cnt  <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end
`else
  assign scl_filt = scl_sync[1];
  assign sda_filt = sda_sync[1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      scl_d <= 1'b1;
      sda_q <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= scl_filt;
      scl_d <= scl_q;
      sda_q <= sda_filt;
      sda_d <= sda_q;
    end
  end

  assign scl_rise = scl_q & ~scl_d;
  assign scl_fall = ~scl_q & scl_d;
  assign start    = scl_q & scl_d & sda_d & ~sda_q;
  assign stop     = scl_q & scl_d & ~sda_d & sda_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      sh         <= 7'd0;
      phase      <= 1'b0;
      nack       <= 1'b0;
      sda_oe_o   <= 1'b0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      dir_o      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_req_o   <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
        phase    <= 1'b0;
      end else if (start) begin
        state    <= ADDR;
        cnt      <= 3'd0;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b1;
        phase    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sda_oe_o <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              sh  <= {sh[5:0], sda_q};
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                dir_o <= sda_q;
                phase <= 1'b0;
                state <= (sh == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase    <= 1'b1;
                sda_oe_o <= 1'b1;
              end else begin
                phase <= 1'b0;
                cnt   <= 3'd0;
                if (dir_o) begin
                  // First read bit goes out on the same fall that ends the ACK clock.
                  tx_req_o <= 1'b1;
                  sh       <= tx_data_i[6:0];
                  sda_oe_o <= ~tx_data_i[7];
                  state    <= RD_BYTE;
                end else begin
                  sda_oe_o <= 1'b0;
                  state    <= WR_BYTE;
                end
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              sh  <= {sh[5:0], sda_q};
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                rx_data_o  <= {sh, sda_q};
                rx_valid_o <= rx_ready_i;
                nack       <= ~rx_ready_i;
                phase      <= 1'b0;
                state      <= WR_ACK;
              end
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                phase    <= 1'b1;
                sda_oe_o <= ~nack;
              end else begin
                phase    <= 1'b0;
                sda_oe_o <= 1'b0;
                cnt      <= 3'd0;
                state    <= nack ? WAIT_STOP : WR_BYTE;
              end
            end
          end

          RD_BYTE: begin
            if (scl_fall) begin
              if (cnt == 3'd7) begin
                sda_oe_o <= 1'b0;
                phase    <= 1'b0;
                state    <= RD_ACK;
              end else begin
                sh       <= {sh[5:0], 1'b0};
                sda_oe_o <= ~sh[6];
                cnt      <= cnt + 3'd1;
              end
            end
          end

          RD_ACK: begin
            // phase marks that the master ACKed on the 9th rise; reload on the following fall.
            if (scl_rise) begin
              if (sda_q) begin
                state <= WAIT_STOP;
              end else begin
                phase <= 1'b1;
              end
            end else if (scl_fall && phase) begin
              phase    <= 1'b0;
              cnt      <= 3'd0;
              tx_req_o <= 1'b1;
              sh       <= tx_data_i[6:0];
              sda_oe_o <= ~tx_data_i[7];
              state    <= RD_BYTE;
            end
          end

          WAIT_STOP: begin
            sda_oe_o <= 1'b0;
          end

          default: begin
            state    <= IDLE;
            sda_oe_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: behavioural I2C master on an open-drain SDA.
module tb_i2c_slave_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       sda_m;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       dir;
  logic       busy;
  wire        sda_bus = sda_m & ~sda_oe;

  int total = 0;
  int bad   = 0;

  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         oe_cycles = 0;
  int         busy_cycles = 0;
  logic [7:0] rx_log[$];

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ready_i (rx_ready),
    .tx_req_o   (tx_req),
    .tx_data_i  (tx_data),
    .dir_o      (dir),
    .busy_o     (busy)
  );

  assign tx_data = (tx_cnt == 0) ? 8'h3C : 8'hF0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_log.push_back(rx_data);
    end
    if (tx_req) tx_cnt++;
    if (sda_oe) oe_cycles++;
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic got);
    clks(5);
    sda_m = b;
    clks(5);
    scl = 1'b1;
    clks(5);
    got = sda_bus;
    clks(5);
    scl = 1'b0;
  endtask

  task automatic do_start();
    sda_m = 1'b0;
    clks(10);
    scl = 1'b0;
  endtask

  task automatic do_rstart();
    clks(5);
    sda_m = 1'b1;
    clks(5);
    scl = 1'b1;
    clks(10);
    sda_m = 1'b0;
    clks(10);
    scl = 1'b0;
  endtask

  task automatic do_stop();
    clks(5);
    sda_m = 1'b0;
    clks(5);
    scl = 1'b1;
    clks(10);
    sda_m = 1'b1;
    clks(10);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--) send_bit(d[i], dummy);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, b);
      d[i] = b;
    end
    send_bit(mack, b);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic       dummy;
    logic [7:0] d;
    int         rx0, tx0, oe0, busy0, log0;

    rst = 1'b1; scl = 1'b1; sda_m = 1'b1; rx_ready = 1'b1;
    clks(5);
    rst = 1'b0;
    clks(5);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_dir", dir, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Write 0x22, 0xA5 to 0x11
    rx0 = rx_cnt; log0 = rx_log.size();
    do_start();
    clks(2);
    check("wr_busy", busy, 1'b1);
    write_byte(8'h22, ack);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_dir", dir, 1'b0);
    write_byte(8'h22, ack);
    check("wr_b0_ack", ack, 1'b0);
    write_byte(8'hA5, ack);
    check("wr_b1_ack", ack, 1'b0);
    do_stop();
    check("wr_rx_cnt", rx_cnt - rx0, 2);
    if (rx_log.size() >= log0 + 2) begin
      check("wr_rx0", rx_log[log0], 8'h22);
      check("wr_rx1", rx_log[log0+1], 8'hA5);
    end else begin
      check("wr_rx_log_size", rx_log.size() - log0, 2);
    end
    check("wr_busy_after_stop", busy, 1'b0);

    // Read 0x3C (ACK), 0xF0 (NACK) from 0x11
    tx0 = tx_cnt;
    do_start();
    write_byte(8'h23, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_dir", dir, 1'b1);
    read_byte(1'b0, d);
    check("rd_b0", d, 8'h3C);
    read_byte(1'b1, d);
    check("rd_b1", d, 8'hF0);
    clks(6);
    check("rd_sda_released", sda_oe, 1'b0);
    check("rd_tx_req_cnt", tx_cnt - tx0, 2);
    do_stop();
    check("rd_busy_after_stop", busy, 1'b0);

    // Address 0x12: no ACK, nothing driven
    rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cycles;
    do_start();
    write_byte(8'h24, ack);
    check("na_addr_nack", ack, 1'b1);
    do_stop();
    check("na_rx_cnt", rx_cnt - rx0, 0);
    check("na_tx_cnt", tx_cnt - tx0, 0);
    check("na_oe_cycles", oe_cycles - oe0, 0);

    // Not-ready sink forces NACK, then repeated START and write 0x55
    rx0 = rx_cnt;
    rx_ready = 1'b0;
    do_start();
    write_byte(8'h22, ack);
    check("nr_addr_ack", ack, 1'b0);
    write_byte(8'h77, ack);
    check("nr_byte_nack", ack, 1'b1);
    check("nr_rx_cnt", rx_cnt - rx0, 0);
    rx_ready = 1'b1;
    do_rstart();
    write_byte(8'h22, ack);
    check("rs_addr_ack", ack, 1'b0);
    write_byte(8'h55, ack);
    check("rs_byte_ack", ack, 1'b0);
    check("rs_rx_data", rx_data, 8'h55);
    check("rs_rx_cnt", rx_cnt - rx0, 1);
    do_stop();

    // STOP after 4 data bits discards the partial byte
    rx0 = rx_cnt;
    do_start();
    write_byte(8'h22, ack);
    check("ps_addr_ack", ack, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, dummy);
    do_stop();
    check("ps_rx_cnt", rx_cnt - rx0, 0);
    check("ps_busy", busy, 1'b0);

    // Reset while the target is pulling SDA low for the data ACK
    do_start();
    write_byte(8'h22, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'b0, dummy);
    for (int i = 0; i < 20 && !sda_oe; i++) clks(1);
    check("rr_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rr_sda_oe", sda_oe, 1'b0);
    check("rr_rx_data", rx_data, 8'h00);
    check("rr_rx_valid", rx_valid, 1'b0);
    check("rr_tx_req", tx_req, 1'b0);
    check("rr_dir", dir, 1'b0);
    check("rr_busy", busy, 1'b0);
    clks(2);
    rst = 1'b0;
    sda_m = 1'b1;
    clks(3);
    scl = 1'b1;
    clks(10);

    // One-cycle SDA low glitch while SCL high
    busy0 = busy_cycles;
    @(negedge clk) sda_m = 1'b0;
    @(negedge clk) sda_m = 1'b1;
    clks(12);
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    check("gl_busy_seen", (busy_cycles - busy0) != 0, 1'b0);
`else
    check("gl_busy_seen", (busy_cycles - busy0) != 0, 1'b1);
`endif
    rst = 1'b1;
    clks(3);
    rst = 1'b0;
    clks(3);
    check("end_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
